// File: rtl/udp_frame_sender_pkg.sv
// Shared types and constants for the UDP frame sender: FSM encodings and
// the UDP payload length helper (2-byte sequence header plus pixel payload).
package udp_frame_sender_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_CHECK = 2'd1,
        R_BURST = 2'd2,
        R_DONE  = 2'd3
    } rd_state_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_REQ  = 3'd2,
        S_HDR0 = 3'd3,
        S_HDR1 = 3'd4,
        S_PAY  = 3'd5,
        S_GAP  = 3'd6
    } tx_state_t;

    function automatic logic [15:0] tx_length(input int unsigned pkt_words);
        return 16'(2 + 2 * pkt_words);
    endfunction

    localparam int unsigned DEF_PKT_WORDS = 512;
    localparam logic [15:0] DEF_TX_LENGTH = tx_length(DEF_PKT_WORDS);

endpackage

// File: rtl/udp_frame_sender_fifo.sv
// Single-clock word buffer between the SDRAM read path and the UDP byte
// stream; dout is registered and updates the cycle after a pop.
module sender_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full buffer is discarded so the count can never wrap.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_dout;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/udp_frame_sender.sv
// Reads one frame of 16-bit pixels from SDRAM and streams it as fixed-size
// UDP packets, each prefixed by a 16-bit big-endian sequence number.
module udp_frame_sender
    import udp_frame_sender_pkg::*;
#(
    parameter int unsigned PKT_WORDS   = 512,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter logic [20:0] BASE_ADDR   = 21'd0,
    parameter int unsigned FIFO_DEPTH  = 1024,
    parameter int unsigned IPG_CYCLES  = 16
) (
    input  logic        udp_clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic        App_rd_en,
    output logic [20:0] App_rd_addr,
    input  logic        App_rd_valid,
    input  logic [31:0] App_rd_dout,
    input  logic        udp_tx_ready,
    output logic        app_tx_data_request,
    input  logic        app_tx_ack,
    output logic        app_tx_data_valid,
    output logic [7:0]  app_tx_data,
    output logic [15:0] app_tx_data_length,
    output logic [1:0]  o_dbg_rd_state,
    output logic [2:0]  o_dbg_tx_state
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [20:0] PKT_LAST  = 21'(PKT_WORDS - 1);
    localparam logic [20:0] FRAME_W21 = 21'(FRAME_WORDS);
    localparam logic [20:0] NUM_PKTS  = 21'(FRAME_WORDS / PKT_WORDS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IPG_CYCLES - 1);
    localparam logic [CNT_W-1:0] PKT_CNT  = CNT_W'(PKT_WORDS);
    localparam logic [15:0] TX_LENGTH = tx_length(PKT_WORDS);

    rd_state_t        r_rd_state, w_rd_next;
    tx_state_t        r_tx_state, w_tx_next;
    logic             r_busy;
    logic             r_frame_done;
    logic [15:0]      r_seq;
    logic [20:0]      r_addr;
    logic [20:0]      r_rd_issued;
    logic [20:0]      r_outstanding;
    logic [20:0]      r_burst_cnt;
    logic [20:0]      r_pkts_sent;
    logic [20:0]      r_word_cnt;
    logic             r_phase;
    logic [GAP_W-1:0] r_gap_cnt;

    logic             w_start_accept;
    logic             w_space_ok;
    logic             w_gap_end;
    logic             w_frame_end;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic [15:0]      w_fifo_dout;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_unused_bits;

    assign w_start_accept = frame_start && !r_busy;
    assign w_fifo_push    = App_rd_valid && r_busy;
    // Reserve room for returns still in flight so the buffer cannot overflow.
    assign w_space_ok = (23'(w_fifo_count) + 23'(r_outstanding) + 23'(PKT_WORDS))
                        <= 23'(FIFO_DEPTH);
    assign w_gap_end   = (r_tx_state == S_GAP) && (r_gap_cnt == GAP_LAST);
    assign w_frame_end = w_gap_end && ((r_pkts_sent + 21'd1) == NUM_PKTS);
    assign w_unused_bits = ^{App_rd_dout[31:16], w_fifo_full, w_fifo_empty};

    assign busy               = r_busy;
    assign frame_done         = r_frame_done;
    assign App_rd_addr        = r_addr;
    assign app_tx_data_length = TX_LENGTH;
    assign o_dbg_rd_state     = r_rd_state;
    assign o_dbg_tx_state     = r_tx_state;

    sender_sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (udp_clk),
        .i_rst_n (rst_n),
        .i_push  (w_fifo_push),
        .i_din   (App_rd_dout[15:0]),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
            r_tx_state <= S_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_start_accept) w_rd_next = R_CHECK;
            R_CHECK: begin
                if (r_rd_issued == FRAME_W21) w_rd_next = R_DONE;
                else if (w_space_ok)          w_rd_next = R_BURST;
            end
            R_BURST: if (r_burst_cnt == PKT_LAST) w_rd_next = R_CHECK;
            R_DONE:  if (w_frame_end) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE: if (w_start_accept) w_tx_next = S_WAIT;
            S_WAIT: if ((w_fifo_count >= PKT_CNT) && udp_tx_ready) w_tx_next = S_REQ;
            S_REQ:  if (app_tx_ack) w_tx_next = S_HDR0;
            S_HDR0: w_tx_next = S_HDR1;
            S_HDR1: w_tx_next = S_PAY;
            S_PAY:  if (r_phase && (r_word_cnt == PKT_LAST)) w_tx_next = S_GAP;
            S_GAP:  if (w_gap_end) w_tx_next = w_frame_end ? S_IDLE : S_WAIT;
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        App_rd_en = (r_rd_state == R_BURST);
    end

    // The first word is popped during the low header byte so that it is on
    // dout when the payload begins; later pops land on each low payload byte.
    always_comb begin
        app_tx_data_request = 1'b0;
        app_tx_data_valid   = 1'b0;
        app_tx_data         = 8'h00;
        w_fifo_pop          = 1'b0;
        case (r_tx_state)
            S_REQ:  app_tx_data_request = 1'b1;
            S_HDR0: begin
                app_tx_data_valid = 1'b1;
                app_tx_data       = r_seq[15:8];
            end
            S_HDR1: begin
                app_tx_data_valid = 1'b1;
                app_tx_data       = r_seq[7:0];
                w_fifo_pop        = 1'b1;
            end
            S_PAY: begin
                app_tx_data_valid = 1'b1;
                app_tx_data       = r_phase ? w_fifo_dout[7:0] : w_fifo_dout[15:8];
                w_fifo_pop        = r_phase && (r_word_cnt != PKT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_rd_issued   <= '0;
            r_burst_cnt   <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_start_accept) begin
                r_addr      <= BASE_ADDR;
                r_rd_issued <= '0;
                r_burst_cnt <= '0;
            end else if (r_rd_state == R_BURST) begin
                r_addr      <= r_addr + 21'd1;
                r_rd_issued <= r_rd_issued + 21'd1;
                r_burst_cnt <= (r_burst_cnt == PKT_LAST) ? 21'd0 : r_burst_cnt + 21'd1;
            end
            case ({App_rd_en, w_fifo_push})
                2'b10:   r_outstanding <= r_outstanding + 21'd1;
                2'b01:   r_outstanding <= r_outstanding - 21'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_seq        <= '0;
            r_pkts_sent  <= '0;
            r_phase      <= 1'b0;
            r_word_cnt   <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_start_accept) begin
                r_busy <= 1'b1;
            end else if (w_frame_end) begin
                r_busy <= 1'b0;
            end
            if (w_start_accept) begin
                r_seq       <= '0;
                r_pkts_sent <= '0;
            end else if (w_gap_end) begin
                r_seq       <= r_seq + 16'd1;
                r_pkts_sent <= r_pkts_sent + 21'd1;
            end
            r_phase <= (r_tx_state == S_PAY) ? ~r_phase : 1'b0;
            if (r_tx_state != S_PAY) begin
                r_word_cnt <= '0;
            end else if (r_phase) begin
                r_word_cnt <= r_word_cnt + 21'd1;
            end
            r_gap_cnt <= (r_tx_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_udp_frame_sender.sv
// Bench for udp_frame_sender: SDRAM and UDP stack models, a byte scoreboard
// fed from a frame-level reference model, and directed plus random frames.
module tb_udp_frame_sender;

    localparam int unsigned PKT_WORDS   = 4;
    localparam int unsigned FRAME_WORDS = 16;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned IPG_CYCLES  = 4;
    localparam logic [20:0] BASE_ADDR   = 21'h1FFFFA;
    localparam int unsigned NUM_PKTS    = FRAME_WORDS / PKT_WORDS;
    localparam int unsigned PKT_BYTES   = 2 + 2 * PKT_WORDS;

    logic        udp_clk;
    logic        rst_n;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
    logic        App_rd_en;
    logic [20:0] App_rd_addr;
    logic        App_rd_valid;
    logic [31:0] App_rd_dout;
    logic        udp_tx_ready;
    logic        app_tx_data_request;
    logic        app_tx_ack;
    logic        app_tx_data_valid;
    logic [7:0]  app_tx_data;
    logic [15:0] app_tx_data_length;
    logic [1:0]  dbg_rd_state;
    logic [2:0]  dbg_tx_state;

    udp_frame_sender #(
        .PKT_WORDS   (PKT_WORDS),
        .FRAME_WORDS (FRAME_WORDS),
        .BASE_ADDR   (BASE_ADDR),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .IPG_CYCLES  (IPG_CYCLES)
    ) dut (
        .udp_clk             (udp_clk),
        .rst_n               (rst_n),
        .frame_start         (frame_start),
        .busy                (busy),
        .frame_done          (frame_done),
        .App_rd_en           (App_rd_en),
        .App_rd_addr         (App_rd_addr),
        .App_rd_valid        (App_rd_valid),
        .App_rd_dout         (App_rd_dout),
        .udp_tx_ready        (udp_tx_ready),
        .app_tx_data_request (app_tx_data_request),
        .app_tx_ack          (app_tx_ack),
        .app_tx_data_valid   (app_tx_data_valid),
        .app_tx_data         (app_tx_data),
        .app_tx_data_length  (app_tx_data_length),
        .o_dbg_rd_state      (dbg_rd_state),
        .o_dbg_tx_state      (dbg_tx_state)
    );

    initial begin
        udp_clk = 1'b0;
        forever #4 udp_clk = ~udp_clk;
    end

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SDRAM contents: a salted function of the word address.
    logic [15:0] salt = 16'h0000;
    function automatic logic [15:0] mem_word(input logic [20:0] a, input logic [15:0] s);
        return (16'h0100 + a[15:0]) ^ s;
    endfunction

    int cyc = 0;
    int lat_min = 3;
    int lat_max = 3;
    int last_due = 0;
    int rd_cnt = 0;
    int rd_due_q[$];
    logic [15:0] rd_data_q[$];

    initial begin
        int due;
        App_rd_valid = 1'b0;
        App_rd_dout  = '0;
        forever begin
            @(negedge udp_clk);
            cyc++;
            if (!rst_n) begin
                rd_due_q.delete();
                rd_data_q.delete();
                last_due = 0;
                App_rd_valid = 1'b0;
            end else begin
                if (App_rd_en) begin
                    due = cyc + int'($urandom_range(lat_max, lat_min));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    rd_due_q.push_back(due);
                    rd_data_q.push_back(mem_word(App_rd_addr, salt));
                    rd_cnt++;
                end
                if (rd_due_q.size() != 0 && rd_due_q[0] <= cyc) begin
                    void'(rd_due_q.pop_front());
                    App_rd_dout  = {16'($urandom()), rd_data_q.pop_front()};
                    App_rd_valid = 1'b1;
                end else begin
                    App_rd_valid = 1'b0;
                    App_rd_dout  = $urandom();
                end
            end
        end
    end

    // UDP stack: ready level (0 low, 1 high, 2 random) and delayed ack.
    int ready_mode = 1;
    initial begin
        udp_tx_ready = 1'b0;
        forever begin
            udp_tx_ready = (ready_mode == 2) ? ($urandom_range(3, 0) != 0) : (ready_mode == 1);
            @(negedge udp_clk);
        end
    end

    int ack_min = 0;
    int ack_max = 2;
    initial begin
        int req_run;
        int cur_delay;
        bit acked;
        req_run = 0;
        cur_delay = 0;
        acked = 1'b0;
        app_tx_ack = 1'b0;
        forever begin
            @(negedge udp_clk);
            app_tx_ack = 1'b0;
            if (!rst_n) begin
                req_run = 0;
                acked = 1'b0;
            end else if (acked) begin
                check("req_drop_after_ack", app_tx_data_request, 0);
                check("hdr_after_ack", app_tx_data_valid, 1);
                acked = 1'b0;
                req_run = 0;
            end else if (app_tx_data_request) begin
                if (req_run == 0) cur_delay = int'($urandom_range(ack_max, ack_min));
                req_run++;
                if (req_run == cur_delay + 1) begin
                    app_tx_ack = 1'b1;
                    acked = 1'b1;
                end
            end else if (req_run != 0) begin
                check("req_held_until_ack", app_tx_data_request, 1);
                req_run = 0;
            end
        end
    end

    // Monitor: pops the expected byte stream and checks packet framing.
    int run = 0;
    int bytes_seen = 0;
    int pkts_seen = 0;
    int done_cnt = 0;
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge udp_clk);
            if (!rst_n) begin
                run = 0;
            end else begin
                if (frame_done) done_cnt++;
                if (app_tx_data_valid) begin
                    check("valid_during_req", app_tx_data_request, 0);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h, expected none", app_tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", app_tx_data, e);
                    end
                    run++;
                    bytes_seen++;
                end else if (run != 0) begin
                    check("pkt_len", run, PKT_BYTES);
                    check("tx_length", app_tx_data_length, PKT_BYTES);
                    run = 0;
                    pkts_seen++;
                end
            end
        end
    end

    // Reference model: the whole frame's byte stream from the packet rules.
    task automatic start_frame(input logic [15:0] first_seq);
        logic [15:0] seq;
        logic [15:0] w;
        logic [20:0] a;
        salt = 16'($urandom());
        for (int p = 0; p < int'(NUM_PKTS); p++) begin
            seq = first_seq + 16'(p);
            exp_q.push_back(seq[15:8]);
            exp_q.push_back(seq[7:0]);
            for (int i = 0; i < int'(PKT_WORDS); i++) begin
                a = BASE_ADDR + 21'(p * PKT_WORDS + i);
                w = mem_word(a, salt);
                exp_q.push_back(w[15:8]);
                exp_q.push_back(w[7:0]);
            end
        end
        @(negedge udp_clk);
        frame_start = 1'b1;
        @(negedge udp_clk);
        frame_start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic pulse_start();
        @(negedge udp_clk);
        frame_start = 1'b1;
        @(negedge udp_clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input string name, input int pk0);
        int t;
        t = 0;
        do begin
            @(negedge udp_clk);
            t++;
        end while (!frame_done && t < 3000);
        if (!frame_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no frame_done, expected one within 3000 cycles", name);
        end else begin
            @(negedge udp_clk);
            check("busy_after_done", busy, 0);
            check("done_one_cycle", frame_done, 0);
            check("all_bytes_sent", exp_q.size(), 0);
            check("pkts_in_frame", pkts_seen - pk0, NUM_PKTS);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_rd_en"}, App_rd_en, 0);
        check({tag, "_rd_addr"}, App_rd_addr, 0);
        check({tag, "_request"}, app_tx_data_request, 0);
        check({tag, "_valid"}, app_tx_data_valid, 0);
        check({tag, "_data"}, app_tx_data, 0);
    endtask

    initial begin
        int pk0;
        int rd0;
        int b0;
        int d0;
        int t;
        rst_n = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge udp_clk);
        check_outputs_zero("reset");
        check("reset_length", app_tx_data_length, PKT_BYTES);
        rst_n = 1'b1;
        repeat (2) @(negedge udp_clk);

        // Basic frame.
        pk0 = pkts_seen;
        start_frame(16'h0000);
        wait_frame_done("basic", pk0);

        // Long ack delay: request held 50 cycles.
        ack_min = 49;
        ack_max = 49;
        pk0 = pkts_seen;
        start_frame(16'h0000);
        wait_frame_done("ack_delay", pk0);
        ack_min = 0;
        ack_max = 2;

        // Backpressure: reads stop once the buffer is reserved.
        ready_mode = 0;
        rd0 = rd_cnt;
        b0 = bytes_seen;
        pk0 = pkts_seen;
        start_frame(16'h0000);
        repeat (200) @(negedge udp_clk);
        check("reads_while_stalled", rd_cnt - rd0, FIFO_DEPTH);
        check("no_bytes_while_stalled", bytes_seen - b0, 0);
        ready_mode = 1;
        wait_frame_done("backpressure", pk0);

        // Start while busy is ignored.
        pk0 = pkts_seen;
        d0 = done_cnt;
        start_frame(16'h0000);
        repeat (20) @(negedge udp_clk);
        pulse_start();
        wait_frame_done("start_busy", pk0);
        repeat (60) @(negedge udp_clk);
        check("start_busy_done_count", done_cnt - d0, 1);
        check("start_busy_idle", busy, 0);

        // Reset in the middle of packet 0 payload, then a clean restart.
        b0 = bytes_seen;
        start_frame(16'h0000);
        t = 0;
        while (bytes_seen < b0 + 5 && t < 1000) begin
            @(negedge udp_clk);
            t++;
        end
        check("reached_byte5", (bytes_seen >= b0 + 5), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        repeat (3) @(negedge udp_clk);
        check("midreset_no_reads", App_rd_en, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge udp_clk);
        pk0 = pkts_seen;
        start_frame(16'h0000);
        wait_frame_done("restart", pk0);

        // Sequence wrap: seq forced to FFFF before the first header.
        pk0 = pkts_seen;
        start_frame(16'hFFFF);
        force dut.r_seq = 16'hFFFF;
        @(negedge udp_clk);
        release dut.r_seq;
        wait_frame_done("seq_wrap", pk0);

        // Random latency, ack delay and ready.
        lat_min = 1;
        lat_max = 8;
        ack_max = 6;
        ready_mode = 2;
        for (int f = 0; f < 4; f++) begin
            pk0 = pkts_seen;
            start_frame(16'h0000);
            wait_frame_done("random", pk0);
        end
        ready_mode = 1;

        repeat (5) @(negedge udp_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #700000;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected finish before 700000 ns");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/udp_frame_sender.md
Name: udp_frame_sender

Overview:
- Transmit-side counterpart of the UDP-to-SDRAM receive path.
- On a start pulse, reads one frame of 16-bit pixel words from SDRAM into an internal buffer and sends it as fixed-size UDP packets to the UDP stack's application TX interface.
- Each packet is a 2-byte sequence header followed by the pixel payload.
- The header is what the receive side strips, so a looped-back frame lands at the same SDRAM layout.

Parameters:
- PKT_WORDS, 512: pixel words per packet. Payload is 2*PKT_WORDS bytes.
- FRAME_WORDS, 307200: words per frame. Must be a multiple of PKT_WORDS.
- BASE_ADDR, 21'd0: SDRAM word address of the frame's first word.
- FIFO_DEPTH, 1024: buffer depth in 16-bit words. Power of two, at least 2*PKT_WORDS.
- IPG_CYCLES, 16: idle cycles after each packet.

Ports:
- udp_clk  in  1  single 125 MHz clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse that starts a frame
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last byte of the frame
- App_rd_en  out  1  SDRAM read request, one word per cycle
- App_rd_addr  out  21  SDRAM read word address
- App_rd_valid  in  1  read data valid, arbitrary latency, returns in order
- App_rd_dout  in  32  read data; only bits [15:0] are used
- udp_tx_ready  in  1  UDP stack can accept a packet request
- app_tx_data_request  out  1  packet send request
- app_tx_ack  in  1  stack grants the request; payload starts next cycle
- app_tx_data_valid  out  1  TX byte valid
- app_tx_data  out  8  TX byte
- app_tx_data_length  out  16  UDP payload length, constant 2+2*PKT_WORDS

Behaviour:
- Reset values:
  - All outputs are 0, except app_tx_data_length, which is constant.
  - Both FSMs go to IDLE, FIFO is emptied, all counters are cleared.
  - Reset mid-frame aborts the frame immediately: no frame_done, no further reads.
- Start:
  - frame_start is accepted only when busy=0. A start while busy is ignored.
  - On accept: busy=1 next cycle, seq=0, read address=BASE_ADDR, rd_issued=0, pkts_sent=0.
- Reader FSM, states R_IDLE, R_CHECK, R_BURST, R_DONE:
  - R_CHECK goes to R_BURST when rd_issued < FRAME_WORDS and (fifo_count + outstanding + PKT_WORDS) <= FIFO_DEPTH.
  - R_BURST asserts App_rd_en for exactly PKT_WORDS consecutive cycles, incrementing the address each cycle, then returns to R_CHECK.
  - When rd_issued == FRAME_WORDS, go to R_DONE. Stay there until the sender finishes, then go to R_IDLE.
  - outstanding = issued minus returned. It increments on App_rd_en, decrements on App_rd_valid, and is unchanged when both occur in the same cycle.
- FIFO writes:
  - App_rd_valid writes App_rd_dout[15:0] into the FIFO.
  - The space reservation guarantees no overflow. A write while full is dropped and never corrupts the count.
- Sender FSM, states S_IDLE, S_WAIT, S_REQ, S_HDR0, S_HDR1, S_PAY, S_GAP:
  - S_WAIT goes to S_REQ when fifo_count >= PKT_WORDS and udp_tx_ready=1.
  - S_REQ holds app_tx_data_request=1 until app_tx_ack; request drops the cycle after ack.
  - S_HDR0 emits seq[15:8]; S_HDR1 emits seq[7:0].
  - S_PAY pops one word every 2 cycles and emits word[15:8] then word[7:0]. app_tx_data_valid stays high continuously for 2+2*PKT_WORDS cycles.
  - S_GAP idles IPG_CYCLES cycles. Then seq increments (wrapping 16'hFFFF to 0) and pkts_sent increments.
  - If pkts_sent == FRAME_WORDS/PKT_WORDS, pulse frame_done, clear busy, go to S_IDLE. Otherwise go to S_WAIT.
  - Loss of udp_tx_ready after ack does not pause payload output.
- FIFO simultaneous push and pop in one cycle leaves the count unchanged.
- All counters are 21 bits, except seq (16 bits) and the gap counter. Address arithmetic is modulo 2^21.

Decomposition:
- Shared package: FSM state encodings, and a localparam for length = 2+2*PKT_WORDS computed from the parameter.
- One sub-module, sender_sync_fifo: single-clock FIFO, 16 bits × FIFO_DEPTH, with push, pop, dout, count, full and empty, and first-word latency of one cycle after pop.

Test Plan:
- Basic frame, PKT_WORDS=4, FRAME_WORDS=8, SDRAM model with latency 3 holding word i = 16'h0100+i:
  - 2 packets, app_tx_data_length=10.
  - Packet 0 bytes: 00 00 01 00 01 01 01 02 01 03.
  - Packet 1 starts 00 01 and carries words 4..7.
  - Exactly one frame_done pulse, then busy=0.
- Ack delay, udp_tx_ready=1 but app_tx_ack held off 50 cycles:
  - Request stays high for 50 cycles.
  - No byte is output before the ack.
  - After the ack, valid is contiguous for 10 cycles.
- Backpressure, FIFO_DEPTH=8, PKT_WORDS=4, FRAME_WORDS=16, udp_tx_ready low for 200 cycles:
  - Reader issues exactly 8 reads, then stalls.
  - No word is dropped.
  - Output sequence is correct after ready rises.
- Start while busy: a second frame_start mid-frame is ignored; total packets = 2.
- Reset mid-payload: rst_n low during packet 0 byte 5:
  - All outputs go to 0 at once.
  - A new frame_start after release restarts with seq=0 at BASE_ADDR.
- Seq wrap: preload seq to 16'hFFFF via a forced long frame; the next packet header is 00 00.
